// File: rtl/kyber_shake_pkg.sv
// Shared types and constants for the SHAKE core scheduler.
package kyber_shake_pkg;

    localparam int SHAKE128_LANES = 21;
    localparam int SHAKE256_LANES = 17;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } shake_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        STREAM
    } sched_state_t;

    // Rate width in 64-bit lanes for the selected SHAKE variant.
    function automatic logic [4:0] lanes_f(input shake_mode_t mode);
        return (mode == SHAKE256) ? 5'(SHAKE256_LANES) : 5'(SHAKE128_LANES);
    endfunction

endpackage

// File: rtl/shake_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module rr_arbiter
#(
    parameter  int NUM_REQ = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [IDW-1:0]     gnt_id,
    output logic               any
);

    always_comb begin
        int j;
        gnt_id = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req_valid[j]) begin
                any    = 1'b1;
                gnt_id = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/shake_scheduler.sv
// Shares one SHAKE/Keccak core between NUM_REQ requesters: arbitrates, runs
// absorb/squeeze permutations and streams each rate block out as 64-bit lanes.
module shake_scheduler
    import kyber_shake_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*256-1:0]     req_seed,
    input  logic [NUM_REQ-1:0]         req_mode,
    input  logic [NUM_REQ*4-1:0]       req_blocks,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_lane,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       out_last,
    output logic                       err,
    output logic                       core_start,
    output logic                       core_squeeze,
    output logic                       core_mode,
    output logic [255:0]               core_in,
    input  logic [1599:0]              core_state,
    input  logic                       core_valid
);

    localparam int              IDW     = $clog2(NUM_REQ);
    localparam logic [IDW-1:0]  LAST_ID = IDW'(NUM_REQ - 1);
    localparam logic [6:0]      TO_LAST = 7'(TIMEOUT - 1);

    sched_state_t        state_q, state_d;
    logic [IDW-1:0]      id_q, id_d, rr_ptr_q, rr_ptr_d;
    shake_mode_t         mode_q, mode_d;
    logic [3:0]          blocks_left_q, blocks_left_d;
    logic [255:0]        seed_q, seed_d;
    logic                first_q, first_d;
    logic [6:0]          cnt_q, cnt_d;
    logic                cv_q, cv_d;
    logic [24:0][63:0]   buf_q, buf_d;
    logic [4:0]          idx_q, idx_d;

    logic [IDW-1:0]      gnt_id;
    logic                gnt_any;
    logic [3:0]          gnt_blocks;
    logic [4:0]          last_lane;
    logic [IDW-1:0]      next_ptr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .gnt_id    (gnt_id),
        .any       (gnt_any)
    );

    assign gnt_blocks = req_blocks[gnt_id*4 +: 4];
    assign last_lane  = lanes_f(mode_q) - 5'd1;
    assign next_ptr   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;

    assign core_in   = seed_q;
    assign core_mode = mode_q;
    assign out_id    = id_q;

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        rr_ptr_d      = rr_ptr_q;
        mode_d        = mode_q;
        blocks_left_d = blocks_left_q;
        seed_d        = seed_q;
        first_d       = first_q;
        cnt_d         = cnt_q;
        cv_d          = core_valid;
        buf_d         = buf_q;
        idx_d         = idx_q;
        req_ack       = '0;
        out_valid     = 1'b0;
        out_lane      = '0;
        out_last      = 1'b0;
        err           = 1'b0;
        core_start    = 1'b0;
        core_squeeze  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    id_d          = gnt_id;
                    seed_d        = req_seed[gnt_id*256 +: 256];
                    mode_d        = shake_mode_t'(req_mode[gnt_id]);
                    blocks_left_d = (gnt_blocks == 4'd0) ? 4'd1 : gnt_blocks;
                    first_d       = 1'b1;
                    state_d       = START;
                end
            end
            START: begin
                core_start   = 1'b1;
                core_squeeze = !first_q;
                if (first_q) req_ack[id_q] = 1'b1;
                first_d = 1'b0;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Only a fresh 0->1 edge counts; a level left over from an
                // earlier permutation must not be mistaken for this one.
                if (core_valid && !cv_q) begin
                    buf_d   = core_state;
                    idx_d   = '0;
                    state_d = STREAM;
                end else if (cnt_q == TO_LAST) begin
                    err      = 1'b1;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else begin
                    cnt_d = (cnt_q == 7'h7f) ? cnt_q : cnt_q + 7'd1;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                out_lane  = buf_q[idx_q];
                out_last  = (idx_q == last_lane) && (blocks_left_q == 4'd1);
                if (out_ready) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == last_lane) begin
                        blocks_left_d = blocks_left_q - 4'd1;
                        if (blocks_left_q == 4'd1) begin
                            rr_ptr_d = next_ptr;
                            state_d  = IDLE;
                        end else begin
                            state_d = START;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            id_q          <= '0;
            rr_ptr_q      <= '0;
            mode_q        <= SHAKE128;
            blocks_left_q <= '0;
            seed_q        <= '0;
            first_q       <= 1'b0;
            cnt_q         <= '0;
            cv_q          <= 1'b0;
            buf_q         <= '0;
            idx_q         <= '0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            rr_ptr_q      <= rr_ptr_d;
            mode_q        <= mode_d;
            blocks_left_q <= blocks_left_d;
            seed_q        <= seed_d;
            first_q       <= first_d;
            cnt_q         <= cnt_d;
            cv_q          <= cv_d;
            buf_q         <= buf_d;
            idx_q         <= idx_d;
        end
    end

endmodule

// File: tb/tb_shake_scheduler.sv
// Directed bench for shake_scheduler with a latency-programmable core stub.
module tb_shake_scheduler;
    import kyber_shake_pkg::*;

    localparam int NR = 2;
    localparam int TO = 20;
    localparam logic [255:0] SEED0  = 256'hf8f11229044dfea54ddc214aaa439e7ea06b9b4ede8a3e3f6dfef500c9665598;
    localparam logic [255:0] SEED1  = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    localparam logic [255:0] DIGEST = 256'hbc560b74bafdfcec6bef89337da01de833c65309e7e3cb6cfff9f5a263aabe16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NR-1:0]         req_valid;
    logic [NR*256-1:0]     req_seed;
    logic [NR-1:0]         req_mode;
    logic [NR*4-1:0]       req_blocks;
    logic [NR-1:0]         req_ack;
    logic                  out_valid, out_ready, out_last, err;
    logic [63:0]           out_lane;
    logic [$clog2(NR)-1:0] out_id;
    logic                  core_start, core_squeeze, core_mode, core_valid;
    logic [255:0]          core_in;
    logic [1599:0]         core_state;

    int n_assert = 0;
    int n_fail   = 0;

    logic          stub_en   = 1'b0;
    logic          gold_en   = 1'b0;
    logic          stub_busy = 1'b0;
    int            stub_cnt  = 0;
    logic [7:0]    perm_no   = 8'd0;
    logic [1599:0] stub_cap  = '0;
    logic [63:0]   got [0:127];

    shake_scheduler #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_seed(req_seed),
        .req_mode(req_mode), .req_blocks(req_blocks), .req_ack(req_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
        .out_id(out_id), .out_last(out_last), .err(err),
        .core_start(core_start), .core_squeeze(core_squeeze), .core_mode(core_mode),
        .core_in(core_in), .core_state(core_state), .core_valid(core_valid)
    );

    always #5 clk = ~clk;

    // Core stub: valid pulses a few cycles after start; state is junk off the valid cycle.
    always @(posedge clk) begin : core_stub
        logic [1599:0] nxt;
        core_valid <= 1'b0;
        core_state <= {25{64'hdeadbeef0badf00d}};
        if (stub_busy) begin
            if (stub_cnt == 0) begin
                stub_busy  <= 1'b0;
                core_valid <= 1'b1;
                core_state <= stub_cap;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end else if (stub_en && core_start) begin
            for (int i = 0; i < 25; i++)
                nxt[i*64 +: 64] = {8'hc0, perm_no, 8'(i), 6'b0, core_squeeze, core_mode, core_in[31:0]};
            if (gold_en && !core_squeeze) nxt[255:0] = DIGEST;
            stub_cap  <= nxt;
            perm_no   <= perm_no + 8'd1;
            stub_busy <= 1'b1;
            stub_cnt  <= 3;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Follows one granted request to its final lane handshake, checking lanes on the fly.
    task automatic collect(input int exp_id, input logic [255:0] seed, input logic mode,
                           input int lanes, input int blocks, input int duty, input bit drop,
                           output int n_lanes, output int n_starts, output logic [7:0] sq,
                           output int first_start, output int n_acks);
        int k = 0, b = 0, cyc = 0, last_hs = -10;
        bit done = 0, pv = 0, pr = 0, cv_seen = 0;
        logic [63:0] plane = '0;
        n_lanes = 0; n_starts = 0; sq = '0; first_start = -1; n_acks = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            out_ready = ($urandom_range(99) < duty);
            if (core_start) begin
                if (first_start < 0) first_start = cyc;
                n_starts++;
                sq = {sq[6:0], core_squeeze};
                chk("core_in", core_in, seed);
                chk("core_mode", core_mode, mode);
                if (n_starts > 1) chk("blk_restart_cycle", cyc, last_hs + 1);
            end
            if (|req_ack) begin
                n_acks++;
                chk("ack_id", req_ack, 1 << exp_id);
                if (drop) req_valid = req_valid & ~req_ack;
            end
            if (err) chk("err_spurious", err, 0);
            if (cv_seen) chk("valid_to_stream", out_valid, 1);
            cv_seen = core_valid;
            if (pv && !pr) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_lane", out_lane, plane);
            end
            if (out_valid) begin
                chk("lane_data", out_lane, stub_cap[k*64 +: 64]);
                chk("lane_id", out_id, exp_id);
                chk("lane_last", out_last, (k == lanes - 1) && (b == blocks - 1));
                if (out_ready) begin
                    if (n_lanes < 128) got[n_lanes] = out_lane;
                    n_lanes++;
                    if (k == lanes - 1) begin
                        k = 0; b++; last_hs = cyc;
                        if (b == blocks) done = 1;
                    end else k++;
                end
            end
            pv = out_valid; pr = out_ready; plane = out_lane; cyc++;
        end
        if (!done) chk("stream_timeout", 0, 1);
    endtask

    initial begin
        int nl, ns, fs, na, err_at, k;
        logic [7:0] sq;
        bit found;
        rst = 1'b1; req_valid = '0; req_seed = '0; req_mode = '0; req_blocks = '0; out_ready = 1'b0;
        idle(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_err", err, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_core_in", core_in, 0);
        chk("rst_state", dut.state_q, IDLE);
        rst = 1'b0;
        idle(2);

        // SHAKE256, one block, golden digest in the first four lanes
        gold_en = 1'b1; stub_en = 1'b1; out_ready = 1'b1;
        req_seed[255:0] = SEED0; req_mode[0] = 1'b1; req_blocks[3:0] = 4'd1; req_valid = 2'b01;
        collect(0, SEED0, 1'b1, 17, 1, 100, 1, nl, ns, sq, fs, na);
        chk("t1_req_to_start", fs, 0);
        chk("t1_lanes", nl, 17);
        chk("t1_starts", ns, 1);
        chk("t1_squeeze_seq", sq, 8'b0);
        chk("t1_acks", na, 1);
        chk("t1_digest", {got[3], got[2], got[1], got[0]}, DIGEST);
        gold_en = 1'b0;
        idle(3);

        // SHAKE128, three blocks: absorb then two squeezes
        req_seed[511:256] = SEED1; req_mode[1] = 1'b0; req_blocks[7:4] = 4'd3; req_valid = 2'b10;
        collect(1, SEED1, 1'b0, 21, 3, 100, 1, nl, ns, sq, fs, na);
        chk("t2_lanes", nl, 63);
        chk("t2_starts", ns, 3);
        chk("t2_squeeze_seq", sq, 8'b011);
        chk("t2_acks", na, 1);
        idle(3);

        // Backpressure at ~30% ready, two SHAKE256 blocks
        req_mode[1] = 1'b1; req_blocks[7:4] = 4'd2; req_valid = 2'b10;
        collect(1, SEED1, 1'b1, 17, 2, 30, 1, nl, ns, sq, fs, na);
        chk("t3_lanes", nl, 34);
        chk("t3_starts", ns, 2);
        out_ready = 1'b1;
        idle(3);

        // blocks=0 behaves as a single block
        req_blocks[7:4] = 4'd0; req_valid = 2'b10;
        collect(1, SEED1, 1'b1, 17, 1, 100, 1, nl, ns, sq, fs, na);
        chk("t4_lanes", nl, 17);
        chk("t4_starts", ns, 1);
        idle(3);

        // Round-robin with both requesters held high
        req_mode = 2'b11; req_blocks = {4'd1, 4'd1}; req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            collect(g % 2, (g % 2) ? SEED1 : SEED0, 1'b1, 17, 1, 100, 0, nl, ns, sq, fs, na);
            chk("rr_first_start", fs, (g == 0) ? 0 : 1);
            chk("rr_acks", na, 1);
            chk("rr_lanes", nl, 17);
        end
        req_valid = '0;
        idle(3);

        // Timeout: stub silent, requester 0 aborts, requester 1 served next
        stub_en = 1'b0; req_mode = 2'b01; req_valid = 2'b11;
        @(negedge clk);
        chk("to_start", core_start, 1);
        chk("to_ack", req_ack, 2'b01);
        req_valid[0] = 1'b0;
        err_at = -1;
        for (int c = 1; c <= TO + 5 && err_at < 0; c++) begin
            @(negedge clk);
            if (err) err_at = c;
        end
        chk("to_err_cycle", err_at, TO);
        stub_en = 1'b1;
        @(negedge clk);
        chk("to_idle", dut.state_q, IDLE);
        chk("to_err_once", err, 0);
        collect(1, SEED1, 1'b0, 21, 1, 100, 1, nl, ns, sq, fs, na);
        chk("to_next_start", fs, 0);
        chk("to_next_lanes", nl, 21);
        idle(3);

        // Reset while lane 5 is on the output
        req_blocks[7:4] = 4'd1; req_valid = 2'b10; out_ready = 1'b1;
        k = 0; found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (|req_ack) req_valid = '0;
            if (out_valid) begin
                if (k == 5) found = 1;
                else k++;
            end
        end
        chk("rs_reached_lane5", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_out_valid", out_valid, 0);
        chk("rs_out_lane", out_lane, 0);
        chk("rs_out_id", out_id, 0);
        chk("rs_core_in", core_in, 0);
        chk("rs_core_start", core_start, 0);
        chk("rs_state", dut.state_q, IDLE);
        rst = 1'b0;
        ns = 0;
        repeat (10) begin
            @(negedge clk);
            if (core_start) ns++;
        end
        chk("rs_no_start", ns, 0);
        req_valid = 2'b01;
        collect(0, SEED0, 1'b1, 17, 1, 100, 1, nl, ns, sq, fs, na);
        chk("rs_recover_start", fs, 0);
        chk("rs_recover_lanes", nl, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shake_scheduler.md
# shake_scheduler

Shares one SHAKE/Keccak core (`shake`) between `NUM_REQ` requesters, such as matrix-A generation (SHAKE128) and CBD noise sampling (SHAKE256 PRF). It arbitrates round-robin and drives the core's absorb and squeeze permutations. It captures each 1600-bit state and streams the rate portion back to the winning requester as 64-bit lanes under ready/valid flow control.

## Interface
- `NUM_REQ`, 2: number of requesters (2..4).
- `TIMEOUT`, 64: maximum cycles to wait for `core_valid` before aborting.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: request pending, held until `req_ack`.
- `req_seed` in NUM_REQ×256: seed per requester, absorbed as the core's `_in`.
- `req_mode` in NUM_REQ: 0 = SHAKE128 (21 rate lanes), 1 = SHAKE256 (17 rate lanes).
- `req_blocks` in NUM_REQ×4: rate blocks to squeeze; 0 is treated as 1.
- `req_ack` out NUM_REQ: one-cycle pulse when the request is accepted.
- `out_valid` out 1: lane valid.
- `out_ready` in 1: consumer ready.
- `out_lane` out 64: state bits [64i+63:64i] of the current block.
- `out_id` out $clog2(NUM_REQ): owner of the current stream.
- `out_last` out 1: final lane of the final block.
- `err` out 1: one-cycle pulse on timeout.
- `core_start` out 1: one-cycle pulse starting a permutation.
- `core_squeeze` out 1: qualifies `core_start`; 0 = absorb `core_in`, 1 = re-permute current state.
- `core_mode` out 1: mode forwarded to the core.
- `core_in` out 256: latched seed.
- `core_state` in 1600: core `state_out`.
- `core_valid` in 1: core `valid`.

## Operation
- FSM states: IDLE, START, WAIT, STREAM.
- IDLE
  - If any `req_valid` is high, pick the first requester at or after `rr_ptr`, cyclically.
  - Latch its seed, mode, blocks and id; set `first=1`; go to START.
- START
  - Assert `core_start` and `core_squeeze=!first`.
  - If `first`, pulse `req_ack[id]`.
  - Clear `first`; go to WAIT; clear the timeout counter.
- WAIT
  - Capture `core_state` into the buffer on the rising edge of `core_valid`, meaning `core_valid`=1 with its registered previous value 0. Then set `idx=0` and go to STREAM.
  - A level already high when WAIT is entered is ignored.
  - If the counter reaches `TIMEOUT`: pulse `err`, set `rr_ptr=id+1`, go to IDLE.
- STREAM
  - Drive `out_valid=1` with `out_lane=buf[idx]`.
  - On `out_ready`, increment `idx`.
  - On the handshake of lane `LANES(mode)-1`: decrement `blocks_left`.
    - If the result is 0, go to IDLE with `rr_ptr=id+1 mod NUM_REQ`.
    - Otherwise go to START (squeeze).
- `out_last` = STREAM && `idx`==LANES-1 && `blocks_left`==1.
- `out_lane`, `out_id` and `out_last` hold stable while `out_valid` && !`out_ready`.
- `req_valid` dropping before `req_ack` withdraws the request. Once latched, the request completes regardless of `req_valid`.
- Capacity lanes (index ≥ LANES) are never emitted.

## Timing
- Reset value 0 for: all outputs, `rr_ptr`, the buffer, counters, and previous `core_valid`. State resets to IDLE.
- `rst` mid-operation aborts in the same edge. No further `core_start`; any core permutation in flight is ignored.
- Request to `core_start`: 1 cycle (IDLE grant cycle T, START at T+1). `req_ack` coincides with the first `core_start`.
- Core done (`core_valid` rising at cycle C) to first `out_valid`: C+1.
- With `out_ready` tied high, one block takes LANES cycles (21 for SHAKE128, 17 for SHAKE256).
- Consecutive blocks: last-lane handshake at cycle L, `core_start` at L+1.
- Back-to-back requests: IDLE costs 1 cycle between the final lane and the next grant.
- Simultaneous `req_valid`: the requester at or after `rr_ptr` wins; the others wait with no ack.
- Timeout counter is 7 bits and saturates; `err` pulses exactly once per abort.

## Structure
- `kyber_shake_pkg` contains:
  - `SHAKE128_LANES=21` and `SHAKE256_LANES=17`.
  - `shake_mode_t`.
  - `sched_state_t` enum with IDLE, START, WAIT and STREAM.
  - `lanes_f(mode)` function.
- One sub-module, `rr_arbiter`: combinational round-robin pick from `req_valid` and `rr_ptr`, returning `gnt_id` and `any`.

## Test plan
- **Reset during STREAM:** assert `rst` at lane 5.
  - Next cycle: all outputs 0, state IDLE.
  - No `core_start` until a new request arrives.
- **SHAKE256, 1 block:** requester 0, seed f8f11229044dfea54ddc214aaa439e7ea06b9b4ede8a3e3f6dfef500c9665598, `out_ready`=1.
  - 17 lanes, `out_last` only on lane 16.
  - {lane3..lane0} matches golden digest bc560b74bafdfcec6bef89337da01de833c65309e7e3cb6cfff9f5a263aabe16.
- **SHAKE128, 3 blocks:** exactly 3 `core_start` pulses (squeeze=0, 1, 1) and 63 lanes. Blocks 2 and 3 match the Keccak golden model.
- **Round-robin:** both requesters held high for 4 requests. Grants alternate 0, 1, 0, 1; `out_id` matches; one `req_ack` per grant.
- **Backpressure:** random `out_ready` at 30% duty. Lane data stays stable while stalled; lane count and order are unchanged.
- **Timeout:** core stub never raises `core_valid`.
  - `err` pulses `TIMEOUT` cycles after `core_start`, then FSM returns to IDLE.
  - The other requester is served next.
